// File: rtl/conv_bn_relu_stream_new_pkg.sv
// Shared definitions for the batch-norm/ReLU pixel stream: default widths and FSM state encoding.
package conv_bn_relu_stream_new_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_FRAC_BITS       = 16;
    localparam int unsigned DEF_IMAGE_SIZE      = 93636;
    localparam int unsigned DEF_CHANNEL_NUM_OUT = 256;
    localparam int unsigned DEF_PXL_CNT_WIDTH   = 17;
    localparam int unsigned DEF_CH_CNT_WIDTH    = 8;

    typedef enum logic {
        StLoad = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/conv_bn_relu_stream_new_mac_sat.sv
// Stages 2 and 3 of the affine pipeline: multiply with round-half-up rescale, then bias add,
// saturation and optional ReLU.
module conv_bn_relu_stream_new_mac_sat
    import conv_bn_relu_stream_new_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter bit          RELU_EN    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_pxl,
    input  logic [DATA_WIDTH-1:0] i_scale,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_pxl
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [PW-1:0] ROUND   = PW'(1) << (FRAC_BITS - 1);

    logic signed [PW-1:0]         w_prod;
    logic signed [PW-1:0]         w_shift;
    logic signed [PW-1:0]         w_sum;
    logic signed [PW-1:0]         w_sat;
    logic [DATA_WIDTH-1:0]        w_res;
    logic                         r_s2_valid;
    logic signed [PW-1:0]         r_s2_shift;
    logic signed [DATA_WIDTH-1:0] r_s2_bias;

    always_comb begin
        w_prod  = PW'($signed(i_pxl)) * PW'($signed(i_scale));
        w_shift = (w_prod + ROUND) >>> FRAC_BITS;
    end

    // The sum cannot overflow PW bits: the rescaled product is at most ~2^(PW-FRAC_BITS-2).
    always_comb begin
        w_sum = r_s2_shift + PW'(r_s2_bias);
        w_sat = w_sum;
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX;
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN;
        end
        w_res = w_sat[DATA_WIDTH-1:0];
        if (RELU_EN && (w_sat < 0)) begin
            w_res = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
            o_valid    <= 1'b0;
            o_pxl      <= '0;
        end else begin
            r_s2_valid <= i_valid;
            o_valid    <= r_s2_valid;
            if (i_valid) begin
                r_s2_shift <= w_shift;
                r_s2_bias  <= $signed(i_bias);
            end
            if (r_s2_valid) begin
                o_pxl <= w_res;
            end
        end
    end

endmodule

// File: rtl/conv_bn_relu_stream_new.sv
// Per-output-channel folded batch-norm affine plus optional ReLU on a channel-planar pixel stream.
// Holds the parameter-load FSM, pixel/channel counters, scale/bias table and pipeline stage 1.
module conv_bn_relu_stream_new
    import conv_bn_relu_stream_new_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS       = DEF_FRAC_BITS,
    parameter int unsigned IMAGE_SIZE      = DEF_IMAGE_SIZE,
    parameter int unsigned CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
    parameter bit          RELU_EN         = 1'b1,
    parameter int unsigned PXL_CNT_WIDTH   = DEF_PXL_CNT_WIDTH,
    parameter int unsigned CH_CNT_WIDTH    = DEF_CH_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid_param_in,
    input  logic [DATA_WIDTH-1:0] i_param_in,
    output logic                  o_param_loaded,
    input  logic                  i_valid_in,
    input  logic [DATA_WIDTH-1:0] i_pxl_in,
    output logic [DATA_WIDTH-1:0] o_pxl_out,
    output logic                  o_valid_out,
    output logic                  o_err_drop
);

    localparam int unsigned PTR_W = CH_CNT_WIDTH + 1;
    localparam logic [PTR_W-1:0]         LAST_PTR = PTR_W'(2 * CHANNEL_NUM_OUT - 1);
    localparam logic [PXL_CNT_WIDTH-1:0] LAST_PXL = PXL_CNT_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [CH_CNT_WIDTH-1:0]  LAST_CH  = CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);

    state_e                    r_state;
    state_e                    w_state_next;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PXL_CNT_WIDTH-1:0]  r_pxl_cnt;
    logic [CH_CNT_WIDTH-1:0]   r_ch_cnt;
    logic [DATA_WIDTH-1:0]     r_scale [CHANNEL_NUM_OUT];
    logic [DATA_WIDTH-1:0]     r_bias  [CHANNEL_NUM_OUT];
    logic                      r_err_drop;
    logic                      r_s1_valid;
    logic [DATA_WIDTH-1:0]     r_s1_pxl;
    logic [DATA_WIDTH-1:0]     r_s1_scale;
    logic [DATA_WIDTH-1:0]     r_s1_bias;
    logic                      w_wr_en;
    logic                      w_accept;
    logic                      w_drop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad: begin
                if (i_valid_param_in && (r_wr_ptr == LAST_PTR)) begin
                    w_state_next = StRun;
                end
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StLoad;
        endcase
    end

    always_comb begin
        o_param_loaded = (r_state == StRun);
        w_wr_en        = (r_state == StLoad) && i_valid_param_in;
        w_accept       = (r_state == StRun) && i_valid_in;
        w_drop         = (r_state == StLoad) && i_valid_in;
    end

    // Table is deliberately not reset; a full reload always follows reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            if (!r_wr_ptr[0]) begin
                r_scale[r_wr_ptr[PTR_W-1:1]] <= i_param_in;
            end else begin
                r_bias[r_wr_ptr[PTR_W-1:1]] <= i_param_in;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_pxl_cnt  <= '0;
            r_ch_cnt   <= '0;
            r_err_drop <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pxl   <= i_pxl_in;
                r_s1_scale <= r_scale[r_ch_cnt];
                r_s1_bias  <= r_bias[r_ch_cnt];
                if (r_pxl_cnt == LAST_PXL) begin
                    r_pxl_cnt <= '0;
                    r_ch_cnt  <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + 1'b1;
                end else begin
                    r_pxl_cnt <= r_pxl_cnt + 1'b1;
                end
            end
        end
    end

    assign o_err_drop = r_err_drop;

    conv_bn_relu_stream_new_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .RELU_EN    (RELU_EN)
    ) u_mac_sat (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (r_s1_valid),
        .i_pxl   (r_s1_pxl),
        .i_scale (r_s1_scale),
        .i_bias  (r_s1_bias),
        .o_valid (o_valid_out),
        .o_pxl   (o_pxl_out)
    );

endmodule
